// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM width default and fade-ramp state encoding
package pwm_pkg;

  localparam int PWM_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP_UP,
    ST_HOLD_HIGH,
    ST_RAMP_DOWN,
    ST_HOLD_LOW
  } fade_state_e;

endpackage

// File: rtl/pwm_fade_ramp_if.sv
// rtl/pwm_fade_ramp_if.sv - control inputs and duty outputs of the fade ramp
interface pwm_fade_ramp_if #(
  parameter int WIDTH = pwm_pkg::PWM_WIDTH
);

  logic             enable;
  logic [WIDTH-1:0] duty_min;
  logic [WIDTH-1:0] duty_max;
  logic [WIDTH-1:0] pwm_value;
  logic             period_start;
  logic             ramp_dir;
  logic             busy;

  modport master (
    output enable, duty_min, duty_max,
    input  pwm_value, period_start, ramp_dir, busy
  );

  modport slave (
    input  enable, duty_min, duty_max,
    output pwm_value, period_start, ramp_dir, busy
  );

endinterface

// File: rtl/pwm_step_timer.sv
// rtl/pwm_step_timer.sv - PWM period counter plus step prescaler
module pwm_step_timer #(
  parameter int WIDTH        = 4,
  parameter int STEP_PERIODS = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic period_start,
  output logic step
);

  localparam int             PW      = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(STEP_PERIODS - 1);

  logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [PW-1:0]    prescale_q, prescale_d;

  always_comb begin
    period_cnt_d = period_cnt_q + 1'b1;
    period_start = &period_cnt_q;
    step         = run && period_start && (prescale_q == PS_LAST);
    prescale_d   = prescale_q;
    // Prescale stays parked at zero while stopped so a restart gets a full interval.
    if (!run) begin
      prescale_d = '0;
    end else if (step) begin
      prescale_d = '0;
    end else if (period_start) begin
      prescale_d = prescale_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt_q <= '0;
      prescale_q   <= '0;
    end else begin
      period_cnt_q <= period_cnt_d;
      prescale_q   <= prescale_d;
    end
  end

endmodule

// File: rtl/pwm_fade_ramp.sv
// rtl/pwm_fade_ramp.sv - triangular breathing duty generator, updates on PWM period boundaries
module pwm_fade_ramp
  import pwm_pkg::*;
#(
  parameter int WIDTH        = PWM_WIDTH,
  parameter int STEP_PERIODS = 16,
  parameter int HOLD_STEPS   = 4
) (
  input logic             clock,
  input logic             reset_n,
  pwm_fade_ramp_if.slave  bus
);

  localparam int            HW        = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS);

  fade_state_e      state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             ramp_dir_q, ramp_dir_d;
  logic             first_q, first_d;
  logic             run;
  logic             step;
  logic             degenerate;

  assign run = bus.enable && (state_q != ST_IDLE);

  pwm_step_timer #(
    .WIDTH        (WIDTH),
    .STEP_PERIODS (STEP_PERIODS)
  ) u_step_timer (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .period_start (bus.period_start),
    .step         (step)
  );

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    hold_cnt_d = hold_cnt_q;
    ramp_dir_d = ramp_dir_q;
    first_d    = first_q;
    degenerate = (bus.duty_min >= bus.duty_max);
    if (!bus.enable) begin
      state_d    = ST_IDLE;
      value_d    = '0;
      hold_cnt_d = '0;
      ramp_dir_d = 1'b0;
      first_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RAMP_UP;
        ST_RAMP_UP: begin
          if (step) begin
            // The first step after idle jumps to the floor instead of counting up from zero.
            if (first_q) begin
              value_d = bus.duty_min;
              first_d = 1'b0;
            end else if (!degenerate && (value_q < bus.duty_max)) begin
              value_d = value_q + 1'b1;
            end else begin
              value_d    = degenerate ? bus.duty_min : bus.duty_max;
              state_d    = ST_HOLD_HIGH;
              hold_cnt_d = '0;
              ramp_dir_d = 1'b1;
            end
          end
        end
        ST_HOLD_HIGH, ST_HOLD_LOW: begin
          if (step) begin
            if (degenerate) begin
              value_d = bus.duty_min;
            end
            if (hold_cnt_q == HOLD_LAST) begin
              state_d = (state_q == ST_HOLD_HIGH) ? ST_RAMP_DOWN : ST_RAMP_UP;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (step) begin
            if (!degenerate && (value_q > bus.duty_min)) begin
              value_d = value_q - 1'b1;
            end else begin
              value_d    = bus.duty_min;
              state_d    = ST_HOLD_LOW;
              hold_cnt_d = '0;
              ramp_dir_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      hold_cnt_q <= '0;
      ramp_dir_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      hold_cnt_q <= hold_cnt_d;
      ramp_dir_q <= ramp_dir_d;
      first_q    <= first_d;
    end
  end

  assign bus.pwm_value = value_q;
  assign bus.ramp_dir  = ramp_dir_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_fade_ramp.sv
// tb/tb_pwm_fade_ramp.sv - scoreboard bench for pwm_fade_ramp
module tb_pwm_fade_ramp;

  typedef struct {
    logic [3:0] value;
    int         gap;
  } exp_t;

  logic clock;
  logic reset_n;

  pwm_fade_ramp_if #(.WIDTH(4)) bus_a ();
  pwm_fade_ramp_if #(.WIDTH(4)) bus_b ();

  pwm_fade_ramp #(.WIDTH(4), .STEP_PERIODS(1), .HOLD_STEPS(1)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  pwm_fade_ramp #(.WIDTH(4), .STEP_PERIODS(3), .HOLD_STEPS(0)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic mon_en = 1'b0;
  logic use_b  = 1'b0;
  logic [3:0] prev_val = 4'd0;
  logic       prev_ps  = 1'b0;
  logic [3:0] mv;
  logic       mps;
  exp_t       e;
  int   clk_cnt  = 0;
  int   last_chg = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) clk_cnt = clk_cnt + 1;

  task automatic chk(input string tag, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  task automatic push(input int v, input int gap);
    exp_t x;
    x.value = 4'(v);
    x.gap   = gap;
    sb_q.push_back(x);
  endtask

  // Every duty change must match the queue head, follow a period_start pulse, and keep its spacing.
  always @(negedge clock) begin
    mv  = use_b ? bus_b.pwm_value : bus_a.pwm_value;
    mps = use_b ? bus_b.period_start : bus_a.period_start;
    if (mon_en && (mv != prev_val)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_change", int'(mv), int'(prev_val));
      end else begin
        e = sb_q.pop_front();
        chk("step_value", int'(mv), int'(e.value));
        chk("on_period_wrap", int'(prev_ps), 1);
        if (e.gap != 0) chk("step_gap", clk_cnt - last_chg, e.gap);
      end
      last_chg = clk_cnt;
    end
    prev_val = mv;
    prev_ps  = mps;
  end

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < budget)) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("sb_drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus_a.period_start && (n < 64));
    if (!bus_a.period_start) chk("ps_timeout", 0, 1);
  endtask

  task automatic restart_a(input int mn, input int mx);
    mon_en = 1'b0;
    bus_a.enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    bus_a.duty_min = 4'(mn);
    bus_a.duty_max = 4'(mx);
    mon_en = 1'b1;
    bus_a.enable = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    bus_a.enable = 1'b0; bus_a.duty_min = 4'd0; bus_a.duty_max = 4'd0;
    bus_b.enable = 1'b0; bus_b.duty_min = 4'd0; bus_b.duty_max = 4'd0;

    repeat (3) @(negedge clock);
    chk("rst_value", int'(bus_a.pwm_value), 0);
    chk("rst_busy", int'(bus_a.busy), 0);
    chk("rst_dir", int'(bus_a.ramp_dir), 0);
    chk("rst_ps", int'(bus_a.period_start), 0);
    reset_n = 1'b1;
    wait_ps(n);
    chk("first_ps", n, 15);
    for (int i = 0; i < 3; i++) begin
      wait_ps(n);
      chk("ps_spacing", n, 16);
    end

    // Full ramp, min=2 max=5, one step per period, one-step dwell.
    #1;
    bus_a.duty_min = 4'd2;
    bus_a.duty_max = 4'd5;
    mon_en = 1'b1;
    bus_a.enable = 1'b1;
    push(2, 0); push(3, 16); push(4, 16); push(5, 16);
    push(4, 64); push(3, 16); push(2, 16); push(3, 64); push(4, 16);
    wait_sb(2000);
    chk("ramp_busy", int'(bus_a.busy), 1);
    chk("ramp_dir_up", int'(bus_a.ramp_dir), 0);

    // Ceiling dropped below the current value while ramping up.
    mon_en = 1'b0;
    bus_a.enable = 1'b0;
    @(negedge clock);
    #1;
    chk("idle_value", int'(bus_a.pwm_value), 0);
    chk("idle_busy", int'(bus_a.busy), 0);
    restart_a(0, 12);
    push(1, 0);
    for (int v = 2; v <= 7; v++) push(v, 16);
    wait_sb(1000);
    chk("pre_drop_dir", int'(bus_a.ramp_dir), 0);
    bus_a.duty_max = 4'd4;
    push(4, 16);
    wait_sb(200);
    chk("drop_dir", int'(bus_a.ramp_dir), 1);
    chk("drop_busy", int'(bus_a.busy), 1);
    push(3, 48);
    wait_sb(300);

    // Enable falls on a step edge: enable must win.
    mon_en = 1'b0;
    wait_ps(n);
    bus_a.enable = 1'b0;
    @(posedge clock);
    #1;
    chk("drop_step_value", int'(bus_a.pwm_value), 0);
    chk("drop_step_busy", int'(bus_a.busy), 0);
    chk("drop_step_dir", int'(bus_a.ramp_dir), 0);
    restart_a(6, 8);
    push(6, 0); push(7, 16); push(8, 16);
    wait_sb(300);

    // Degenerate ranges hold at duty_min.
    restart_a(9, 9);
    push(9, 0);
    wait_sb(200);
    for (int i = 0; i < 10; i++) begin
      wait_ps(n);
      chk("degen_eq_value", int'(bus_a.pwm_value), 9);
      chk("degen_eq_busy", int'(bus_a.busy), 1);
    end
    restart_a(10, 3);
    push(10, 0);
    wait_sb(200);
    for (int i = 0; i < 10; i++) begin
      wait_ps(n);
      chk("degen_inv_value", int'(bus_a.pwm_value), 10);
      chk("degen_inv_busy", int'(bus_a.busy), 1);
    end

    // Prescaled instance: three periods per step, no dwell.
    mon_en = 1'b0;
    bus_a.enable = 1'b0;
    use_b = 1'b1;
    @(negedge clock);
    #1;
    bus_b.duty_min = 4'd1;
    bus_b.duty_max = 4'd3;
    mon_en = 1'b1;
    bus_b.enable = 1'b1;
    push(1, 0); push(2, 48); push(3, 48); push(2, 144); push(1, 48); push(2, 144);
    wait_sb(3000);

    // Asynchronous reset in the middle of a ramp.
    mon_en = 1'b0;
    bus_a.duty_min = 4'd2;
    bus_a.duty_max = 4'd5;
    bus_a.enable = 1'b1;
    n = 0;
    while ((bus_a.pwm_value == 4'd0) && (n < 200)) begin
      @(negedge clock);
      n++;
    end
    chk("pre_reset_active", int'(bus_a.pwm_value != 4'd0), 1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_value", int'(bus_a.pwm_value), 0);
    chk("async_rst_busy", int'(bus_a.busy), 0);
    chk("async_rst_dir", int'(bus_a.ramp_dir), 0);
    chk("async_rst_busy_b", int'(bus_b.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ramp.md
Name: pwm_fade_ramp

Overview:
- Upstream duty-value generator for the simple PWM stage. Produces a triangular "breathing" duty sequence on pwm_value, which the PWM comparator consumes.
- Keeps its own period counter that mirrors the PWM counter. Every duty change lands on a PWM period boundary, so no period ever sees a partial duty.
- Ramp speed and dwell at the extremes are set by parameters.

Parameters:
WIDTH, 4, width of duty value and period counter (matches PWM counter width)
STEP_PERIODS, 16, PWM periods per one-LSB duty step (>=1)
HOLD_STEPS, 4, step intervals spent dwelling at duty_max and at duty_min (>=0)

Ports:
clock  input  1  system clock, same clock as the PWM stage
reset_n  input  1  asynchronous active-low reset
enable  input  1  level; high runs the fade, low returns to idle
duty_min  input  WIDTH  ramp floor, sampled at each step
duty_max  input  WIDTH  ramp ceiling, sampled at each step
pwm_value  output  WIDTH  registered duty value to the PWM comparator
period_start  output  1  one-cycle pulse on the last count of each PWM period (period_cnt == 2^WIDTH-1)
ramp_dir  output  1  1 = ramping/holding high side, 0 = low side
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release) forces: period_cnt=0, prescale=0, hold_cnt=0, state=IDLE, pwm_value=0, period_start=0, ramp_dir=0, busy=0.
- period_cnt: WIDTH-bit free-running increment; wraps 2^WIDTH-1 -> 0. Runs regardless of enable. period_start is combinational decode of period_cnt==all-ones, registered-free.
- Step strobe:
  - prescale counts period_start pulses 0..STEP_PERIODS-1.
  - step=1 in the cycle where period_start=1 and prescale==STEP_PERIODS-1; prescale wraps to 0 in that cycle.
  - All pwm_value updates occur only on step, so the new value is visible from period_cnt==0.
- FSM states: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
  - IDLE:
    - pwm_value=0, prescale held at 0.
    - enable=1 -> RAMP_UP next cycle. prescale starts counting, so the first step arrives after at most STEP_PERIODS periods.
    - On that step, pwm_value<=duty_min.
  - RAMP_UP:
    - On step, if pwm_value<duty_max then pwm_value+1.
    - If pwm_value>=duty_max (including ceiling lowered below current value) then pwm_value<=duty_max, go HOLD_HIGH, hold_cnt=0, ramp_dir=1.
  - HOLD_HIGH:
    - On step, hold_cnt+1.
    - When hold_cnt==HOLD_STEPS -> RAMP_DOWN (HOLD_STEPS=0: leave on the first step).
  - RAMP_DOWN:
    - On step, if pwm_value>duty_min then pwm_value-1.
    - Otherwise pwm_value<=duty_min, go HOLD_LOW, hold_cnt=0, ramp_dir=0.
  - HOLD_LOW: mirror of HOLD_HIGH, then -> RAMP_UP.
- Degenerate range: duty_min>=duty_max.
  - On each step pwm_value<=duty_min.
  - FSM alternates HOLD_HIGH/HOLD_LOW per rules above.
  - pwm_value never leaves duty_min.
- No arithmetic wrap is allowed on pwm_value. Saturate at 0 and at 2^WIDTH-1.
- enable deasserted in any state: next cycle state=IDLE, pwm_value=0, prescale=0, hold_cnt=0, ramp_dir=0. This is immediate, not period-aligned.
- Simultaneous enable fall and step: enable wins.
- reset_n asserted mid-ramp: all outputs to reset values immediately, asynchronously.

Decomposition:
- Shared package pwm_pkg holds:
  - default WIDTH constant, shared with simple PWM
  - state enum/localparams for the five FSM states
- One natural sub-module: pwm_step_timer (period_cnt + prescale, outputs period_start and step). Reusable by other timed PWM effects.
- FSM and pwm_value register remain in pwm_fade_ramp.

Test Plan:
- Reset/idle: reset_n=0 mid-run, enable=1 -> pwm_value=0, busy=0 immediately. Also check period_start pulses every 16 clocks after release (WIDTH=4).
- Full ramp: WIDTH=4, STEP_PERIODS=1, HOLD_STEPS=1, min=2, max=5, enable=1.
  - Expected pwm_value sequence at steps: 2,3,4,5,5(hold),4,3,2,2(hold),3...
  - Each change must occur on the clock where period_cnt wraps to 0.
- Prescale: STEP_PERIODS=3 -> consecutive pwm_value changes exactly 48 clocks apart.
- Ceiling drop: during RAMP_UP at pwm_value=7 with max=12, set max=4 -> next step pwm_value=4, state HOLD_HIGH, ramp_dir=1.
- Degenerate: min=9, max=9 and min=10, max=3 -> pwm_value stays 9 (resp. 10) over 10 steps. Also check busy=1 throughout.
- Enable drop: deassert enable on the same cycle as a step -> next cycle pwm_value=0, state IDLE. Re-enable -> first nonzero value equals duty_min.
